// File: rtl/uart_rx_deserializer_if.sv
// Receiver-side signal bundle for the UART RX deserializer.
//   bit_period : clocks per serial bit (CFGR[15:0])
//   serial_in  : raw rxd pin, asynchronous, idle high
//   data       : last correctly framed byte
//   rx_busy    : frame in progress
//   rx_done    : one-cycle strobe, new byte on data
//   frame_err  : one-cycle strobe, stop bit sampled low
// master = the side that configures and drives the line; slave = the receiver.
interface uart_rx_deserializer_if;
  logic [15:0] bit_period;
  logic        serial_in;
  logic [7:0]  data;
  logic        rx_busy;
  logic        rx_done;
  logic        frame_err;

  modport master (
    output bit_period, serial_in,
    input  data, rx_busy, rx_done, frame_err
  );

  modport slave (
    input  bit_period, serial_in,
    output data, rx_busy, rx_done, frame_err
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receiver, 8N1, LSB first.
// Synchronises the asynchronous rxd pin, validates the start bit at its centre, majority-samples
// each data bit at its centre and presents the byte with a one-cycle rx_done strobe. A low stop
// bit gives a one-cycle frame_err strobe and the receiver then waits for the line to go high.
// Ports:
//   clk  : system clock
//   nrst : synchronous, active-low reset
//   bus  : slave side of uart_rx_deserializer_if (bit_period, serial_in in;
//          data, rx_busy, rx_done, frame_err out)
module uart_rx_deserializer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_PERIOD  = 4
) (
  input logic                   clk,
  input logic                   nrst,
  uart_rx_deserializer_if.slave bus
);

  localparam logic [15:0] MinPeriod = 16'(MIN_PERIOD);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [2:0]             hist_q;
  logic                   rxs;
  logic                   maj;
  logic                   full_tick;
  logic                   half_tick;
  logic                   disabled;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        rx_busy_q;
  logic        rx_done_q;
  logic        frame_err_q;

  // Synchroniser and sample history both reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_q <= '1;
      hist_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.serial_in};
      hist_q <= {hist_q[1:0], rxs};
    end
  end

  assign rxs       = sync_q[SYNC_STAGES-1];
  assign maj       = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign full_tick = (cnt_q == (bus.bit_period - 16'd1));
  assign half_tick = (cnt_q == ((bus.bit_period >> 1) - 16'd1));
  assign disabled  = (bus.bit_period < MinPeriod);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      rx_busy_q   <= 1'b0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      if (disabled) begin
        // Too short a bit period: abandon any frame silently.
        state_q   <= StIdle;
        cnt_q     <= '0;
        idx_q     <= '0;
        rx_busy_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            cnt_q <= '0;
            if (!rxs) begin
              state_q   <= StStart;
              rx_busy_q <= 1'b1;
            end
          end
          StStart: begin
            if (half_tick) begin
              cnt_q <= '0;
              idx_q <= '0;
              if (maj) begin
                // Start bit not low at its centre: treat as a glitch.
                state_q   <= StIdle;
                rx_busy_q <= 1'b0;
              end else begin
                state_q <= StData;
              end
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          StData: begin
            if (full_tick) begin
              cnt_q   <= '0;
              shift_q <= {maj, shift_q[7:1]};
              idx_q   <= idx_q + 3'd1;
              if (idx_q == 3'd7) begin
                state_q <= StStop;
              end
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          StStop: begin
            if (full_tick) begin
              cnt_q <= '0;
              if (maj) begin
                data_q    <= shift_q;
                rx_done_q <= 1'b1;
                rx_busy_q <= 1'b0;
                state_q   <= StIdle;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= StBreak;
              end
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          StBreak: begin
            // A held-low line reports only one framing error.
            cnt_q <= '0;
            if (rxs) begin
              state_q   <= StIdle;
              rx_busy_q <= 1'b0;
            end
          end
          default: begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rx_busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data      = data_q;
  assign bus.rx_busy   = rx_busy_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Testbench for uart_rx_deserializer: directed and random 8N1 frames checked against a
// byte-level model (expected byte stream, error count, last good byte).
module tb_uart_rx_deserializer;

  logic clk;
  logic nrst;

  uart_rx_deserializer_if u_if ();

  uart_rx_deserializer #(
    .SYNC_STAGES(2),
    .MIN_PERIOD (4)
  ) u_dut (
    .clk (clk),
    .nrst(nrst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observed side
  logic [7:0] got_q[$];
  int         err_cnt     = 0;
  int         both_cnt    = 0;
  int         busy_cycles = 0;

  // Model side
  logic [7:0] exp_q[$];
  int         exp_err    = 0;
  logic [7:0] model_data = 8'h00;

  always @(negedge clk) begin
    if (nrst) begin
      if (u_if.rx_done) got_q.push_back(u_if.data);
      if (u_if.frame_err) err_cnt++;
      if (u_if.rx_done && u_if.frame_err) both_cnt++;
      if (u_if.rx_busy) busy_cycles++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v, input int n);
    u_if.serial_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bp);
    send_bit(1'b0, bp);
    for (int i = 0; i < 8; i++) send_bit(b[i], bp);
    send_bit(stop, bp);
  endtask

  task automatic model_good(input logic [7:0] b);
    exp_q.push_back(b);
    model_data = b;
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "_ferr"}, err_cnt, exp_err);
    check({tag, "_data"}, u_if.data, model_data);
  endtask

  initial begin
    logic [7:0] b;
    int         bp;
    int         half;

    nrst            = 1'b0;
    u_if.serial_in  = 1'b1;
    u_if.bit_period = 16'd16;
    repeat (4) @(negedge clk);
    check("rst_data", u_if.data, 8'h00);
    check("rst_busy", u_if.rx_busy, 1'b0);
    check("rst_done", u_if.rx_done, 1'b0);
    check("rst_ferr", u_if.frame_err, 1'b0);
    nrst = 1'b1;
    send_bit(1'b1, 20);

    // Clean 0xA5: busy spans half a start bit, eight data bits and the stop bit.
    bp          = 16;
    busy_cycles = 0;
    send_frame(8'hA5, 1'b1, bp);
    send_bit(1'b1, 20);
    model_good(8'hA5);
    check_rx("a5");
    check("a5_busy_len", busy_cycles, (bp / 2) + 9 * bp);

    // Short low pulse: start rejected at the half-bit point.
    busy_cycles = 0;
    send_bit(1'b0, 5);
    send_bit(1'b1, 40);
    check("glitch_busy_len", busy_cycles, bp / 2);
    check("glitch_busy", u_if.rx_busy, 1'b0);
    check_rx("glitch");

    // Bad stop bit followed by a long break.
    send_frame(8'h3C, 1'b0, bp);
    send_bit(1'b0, 20 * bp);
    check("break_busy_hi", u_if.rx_busy, 1'b1);
    send_bit(1'b0, 20 * bp);
    send_bit(1'b1, 32);
    exp_err++;
    check("break_busy_lo", u_if.rx_busy, 1'b0);
    check_rx("break");

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, bp);
    send_frame(8'hFF, 1'b1, bp);
    send_bit(1'b1, 20);
    model_good(8'h00);
    model_good(8'hFF);
    check_rx("b2b");

    // One-clock inversion near the centre of bit 3 of 0x55.
    b    = 8'h55;
    half = bp / 2;
    send_bit(1'b0, bp);
    for (int i = 0; i < 3; i++) send_bit(b[i], bp);
    send_bit(b[3], half - 2);
    send_bit(~b[3], 1);
    send_bit(b[3], bp - half + 1);
    for (int i = 4; i < 8; i++) send_bit(b[i], bp);
    send_bit(1'b1, bp);
    send_bit(1'b1, 20);
    model_good(8'h55);
    check_rx("maj");

    // Reset in the middle of bit 4; the partial byte must vanish.
    b = 8'h5A;
    send_bit(1'b0, bp);
    for (int i = 0; i < 4; i++) send_bit(b[i], bp);
    send_bit(b[4], bp / 2);
    u_if.serial_in = 1'b1;
    nrst           = 1'b0;
    repeat (2) @(negedge clk);
    model_data = 8'h00;
    check("abort_busy", u_if.rx_busy, 1'b0);
    check("abort_data", u_if.data, 8'h00);
    nrst = 1'b1;
    send_bit(1'b1, 20 * bp);
    check_rx("abort");
    send_frame(8'h81, 1'b1, bp);
    send_bit(1'b1, 20);
    model_good(8'h81);
    check_rx("after_abort");

    // Below the minimum period the receiver stays disabled.
    u_if.bit_period = 16'd2;
    send_bit(1'b1, 4);
    busy_cycles = 0;
    send_frame(8'h81, 1'b1, 2);
    send_bit(1'b1, 20);
    check("bp2_busy_len", busy_cycles, 0);
    check_rx("bp2");

    // Random bytes at random bit periods, with random idle gaps.
    for (int n = 0; n < 8; n++) begin
      bp              = int'($urandom_range(24, 8));
      u_if.bit_period = 16'(bp);
      send_bit(1'b1, 4 + int'($urandom_range(2 * bp, 0)));
      b = 8'($urandom);
      send_frame(b, 1'b1, bp);
      send_bit(1'b1, 8);
      model_good(b);
      check_rx("rand");
    end

    check("never_both", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
